// File: rtl/risc_pkg.sv
// Shared constants and types for the instruction fetch path.
//   NOP           : instruction word used for bubbles
//   RESET_VECTOR  : PC value after reset
//   IMM_GROUP     : opcode group (bits 15:13) of two-word instructions
//   INST_W/ADDR_W : instruction and address widths
//   fetch_state_t : fetch FSM state encoding
package risc_pkg;

  localparam int INST_W = 16;
  localparam int ADDR_W = 16;

  localparam logic [INST_W-1:0] NOP          = 16'h0000;
  localparam logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000;
  localparam logic [2:0]        IMM_GROUP    = 3'b110;

  typedef enum logic {
    FETCH_INST = 1'b0,
    FETCH_IMM  = 1'b1
  } fetch_state_t;

  function automatic logic is_two_word(input logic [INST_W-1:0] word);
    return word[INST_W-1 -: 3] == IMM_GROUP;
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter with synchronous reset, parallel load and increment.
//   clk, rst    : clock, synchronous active-high reset (to RESET_VECTOR)
//   load        : load load_value (wins over enable)
//   enable      : advance PC by one, 16-bit modulo
//   load_value  : redirect address
//   pc          : current PC
module pc_register
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              enable,
  input  logic [ADDR_W-1:0] load_value,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VECTOR;
    end else if (load) begin
      pc <= load_value;
    end else if (enable) begin
      pc <= pc + 16'd1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, two-word instruction assembly and IF/ID register.
//   clk, rst       : clock, synchronous active-high reset
//   stall          : hold PC, FSM, hold register and IF/ID
//   branch_taken   : redirect to branch_target, flush to a bubble
//   branch_target  : redirect word address
//   imem_addr      : instruction memory address (the PC)
//   imem_data      : instruction memory data, combinational from imem_addr
//   instruction, immediate, pc_next, if_valid : IF/ID register
//
// state      | meaning
// FETCH_INST | PC points at an instruction's first word
// FETCH_IMM  | first word parked in hold, PC points at its immediate word
module fetch_stage
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] instruction,
  output logic [INST_W-1:0] immediate,
  output logic [ADDR_W-1:0] pc_next,
  output logic              if_valid
);

  fetch_state_t      state;
  logic [INST_W-1:0] hold;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;

  // Branch overrides stall; the PC advances on every non-stalled fetch cycle.
  pc_register u_pc (
    .clk        (clk),
    .rst        (rst),
    .load       (branch_taken),
    .enable     (!stall),
    .load_value (branch_target),
    .pc         (pc)
  );

  assign imem_addr = pc;
  assign pc_inc    = pc + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH_INST;
      hold        <= '0;
      instruction <= NOP;
      immediate   <= '0;
      pc_next     <= '0;
      if_valid    <= 1'b0;
    end else if (branch_taken) begin
      state       <= FETCH_INST;
      hold        <= '0;
      instruction <= NOP;
      immediate   <= '0;
      pc_next     <= '0;
      if_valid    <= 1'b0;
    end else if (!stall) begin
      unique case (state)
        FETCH_INST: begin
          if (is_two_word(imem_data)) begin
            // Park the first word; decode sees a bubble until the immediate arrives.
            hold        <= imem_data;
            state       <= FETCH_IMM;
            instruction <= NOP;
            immediate   <= '0;
            pc_next     <= '0;
            if_valid    <= 1'b0;
          end else begin
            instruction <= imem_data;
            immediate   <= '0;
            pc_next     <= pc_inc;
            if_valid    <= 1'b1;
          end
        end
        FETCH_IMM: begin
          instruction <= hold;
          immediate   <= imem_data;
          pc_next     <= pc_inc;
          if_valid    <= 1'b1;
          state       <= FETCH_INST;
        end
        default: state <= FETCH_INST;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] instruction;
  logic [15:0] immediate;
  logic [15:0] pc_next;
  logic        if_valid;

  logic [15:0] mem [0:65535];

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr];

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .instruction   (instruction),
    .immediate     (immediate),
    .pc_next       (pc_next),
    .if_valid      (if_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] e_inst, input logic [15:0] e_imm,
                            input logic [15:0] e_pcn, input logic e_valid);
    check({tag, ".instruction"}, instruction, e_inst);
    check({tag, ".immediate"}, immediate, e_imm);
    check({tag, ".pc_next"}, pc_next, e_pcn);
    check({tag, ".if_valid"}, {15'd0, if_valid}, {15'd0, e_valid});
  endtask

  task automatic check_bubble(input string tag);
    check({tag, ".instruction"}, instruction, 16'h0000);
    check({tag, ".immediate"}, immediate, 16'h0000);
    check({tag, ".if_valid"}, {15'd0, if_valid}, 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0000] = 16'h1234;
    mem[16'h0001] = 16'h2001;
    mem[16'h0002] = 16'h0F0F;
    mem[16'h0003] = 16'h0000;
    mem[16'h0004] = 16'hC005;
    mem[16'h0005] = 16'hBEEF;
    mem[16'h0040] = 16'h5A5A;
    mem[16'hFFFF] = 16'h0001;

    rst = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 16'h0000;

    // Reset
    step();
    step();
    check_ifid("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    check("reset.imem_addr", imem_addr, 16'h0000);
    rst = 1'b0;

    // Single-word stream
    step();
    check_ifid("sw0", 16'h1234, 16'h0000, 16'h0001, 1'b1);
    check("sw0.imem_addr", imem_addr, 16'h0001);
    step();
    check_ifid("sw1", 16'h2001, 16'h0000, 16'h0002, 1'b1);
    step();
    check_ifid("sw2", 16'h0F0F, 16'h0000, 16'h0003, 1'b1);
    step();
    check_ifid("sw3", 16'h0000, 16'h0000, 16'h0004, 1'b1);

    // Two-word first half -> bubble
    step();
    check_bubble("tw_first");
    check("tw_first.imem_addr", imem_addr, 16'h0005);

    // Stall in FETCH_IMM for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_bubble("stall_imm");
      check("stall_imm.imem_addr", imem_addr, 16'h0005);
    end
    stall = 1'b0;

    step();
    check_ifid("tw_done", 16'hC005, 16'hBEEF, 16'h0006, 1'b1);
    check("tw_done.imem_addr", imem_addr, 16'h0006);
    step();
    check_ifid("tw_once", 16'h0000, 16'h0000, 16'h0007, 1'b1);

    // Branch with stall while in FETCH_IMM
    branch_taken = 1'b1;
    branch_target = 16'h0004;
    step();
    check_bubble("br_to4");
    check("br_to4.imem_addr", imem_addr, 16'h0004);
    branch_taken = 1'b0;
    step();
    check_bubble("br_imm_enter");
    check("br_imm_enter.imem_addr", imem_addr, 16'h0005);
    branch_taken = 1'b1;
    branch_target = 16'h0040;
    stall = 1'b1;
    step();
    check_bubble("br_flush");
    check("br_flush.imem_addr", imem_addr, 16'h0040);
    branch_taken = 1'b0;
    stall = 1'b0;
    step();
    check_ifid("br_target", 16'h5A5A, 16'h0000, 16'h0041, 1'b1);

    // PC wrap
    branch_taken = 1'b1;
    branch_target = 16'hFFFF;
    step();
    check_bubble("wrap_br");
    check("wrap_br.imem_addr", imem_addr, 16'hFFFF);
    branch_taken = 1'b0;
    step();
    check_ifid("wrap", 16'h0001, 16'h0000, 16'h0000, 1'b1);
    check("wrap.imem_addr", imem_addr, 16'h0000);
    step();
    check_ifid("wrap_next", 16'h1234, 16'h0000, 16'h0001, 1'b1);

    // Reset during FETCH_IMM
    branch_taken = 1'b1;
    branch_target = 16'h0004;
    step();
    branch_taken = 1'b0;
    step();
    check("rst_imm_pre.imem_addr", imem_addr, 16'h0005);
    rst = 1'b1;
    step();
    check_ifid("rst_imm", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    check("rst_imm.imem_addr", imem_addr, 16'h0000);
    rst = 1'b0;
    step();
    check_ifid("rst_resume", 16'h1234, 16'h0000, 16'h0001, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
